// File: rtl/main_memory_responder_if.sv
// Cache-to-main-memory request/response bundle.
// The cache drives through the master modport; the memory model uses the slave modport.
interface main_memory_responder_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 10
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 mem_busy;
  logic                 mem_rvalid;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 mem_ack;
  logic                 mem_overrun;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_busy, mem_rvalid, mem_rdata, mem_ack, mem_overrun
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_busy, mem_rvalid, mem_rdata, mem_ack, mem_overrun
  );
endinterface

// File: rtl/main_memory_responder.sv
// Main-memory model for the write-through L1: single-word stores and
// critical-word-first wrapped block reads, each after a fixed access latency.
module main_memory_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 10,
  parameter int DIPTH     = 4,
  parameter int LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  main_memory_responder_if.slave  mem_if
);
  localparam int BW    = $clog2(DIPTH);
  localparam int LW    = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << ADDR_SIZE;

  typedef enum logic [1:0] {IDLE, WAIT, WR_ACK, RD_BURST} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 ack_q, ack_d;
  logic                 ovr_q, ovr_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [WIDTH-1:0]     store_q [DEPTH];
  logic                 go_rsp, rsp_we;
  logic [BW-1:0]        rd_off;
  logic [ADDR_SIZE-1:0] rd_idx;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovr_d   = ovr_q | (mem_if.mem_req && (state_q != IDLE));
    go_rsp  = 1'b0;
    rsp_we  = we_q;
    case (state_q)
      IDLE: begin
        if (mem_if.mem_req) begin
          we_d    = mem_if.mem_we;
          addr_d  = mem_if.mem_addr;
          wdata_d = mem_if.mem_wdata;
          rsp_we  = mem_if.mem_we;
          // WAIT spans LATENCY-1 cycles, so LATENCY=1 responds straight away
          if (LATENCY == 1) begin
            go_rsp = 1'b1;
          end else begin
            state_d = WAIT;
            lat_d   = LW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= LW'(1)) go_rsp = 1'b1;
      end
      WR_ACK: state_d = IDLE;
      RD_BURST: begin
        if (beat_q == BW'(DIPTH - 1)) state_d = IDLE;
        else                          beat_d  = beat_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (go_rsp) begin
      state_d = rsp_we ? WR_ACK : RD_BURST;
      beat_d  = '0;
    end
    rvalid_d = (state_d == RD_BURST);
    ack_d    = (state_d == WR_ACK) || (rvalid_d && (beat_d == BW'(DIPTH - 1)));
    // Offset add is BW bits wide, so the burst wraps inside the block
    rd_off   = addr_d[BW-1:0] + beat_d;
    rd_idx   = {addr_d[ADDR_SIZE-1:BW], rd_off};
    rdata_d  = rvalid_d ? store_q[rd_idx] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      ovr_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      ack_q    <= ack_d;
      ovr_q    <= ovr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else if (state_q == WR_ACK) begin
      store_q[addr_q] <= wdata_q;
    end
  end

  assign mem_if.mem_busy    = (state_q != IDLE);
  assign mem_if.mem_rvalid  = rvalid_q;
  assign mem_if.mem_rdata   = rdata_q;
  assign mem_if.mem_ack     = ack_q;
  assign mem_if.mem_overrun = ovr_q;
endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: stimulus queues expected
// responses, a negedge monitor pops and compares each presented response.
module tb_main_memory_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic        rv;
    logic [31:0] data;
    logic        ack;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  main_memory_responder_if #(.WIDTH(32), .ADDR_SIZE(10)) bus ();

  main_memory_responder #(
    .WIDTH(32), .ADDR_SIZE(10), .DIPTH(4), .LATENCY(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.mem_rvalid || bus.mem_ack)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rvalid=%b ack=%b data=%h expected none",
                 bus.mem_rvalid, bus.mem_ack, bus.mem_rdata);
      end else begin
        mon_e = sb.pop_front();
        check("resp_rvalid", {31'd0, bus.mem_rvalid}, {31'd0, mon_e.rv});
        check("resp_rdata",  bus.mem_rdata, mon_e.data);
        check("resp_ack",    {31'd0, bus.mem_ack},    {31'd0, mon_e.ack});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.mem_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.mem_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  // Returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] wd);
    @(negedge clk);
    wait_idle();
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    @(negedge clk);
    bus.mem_req   = 1'b0;
  endtask

  task automatic store(input logic [9:0] addr, input logic [31:0] wd);
    sb.push_back('{rv: 1'b0, data: 32'd0, ack: 1'b1});
    issue(1'b1, addr, wd);
    wait_idle();
  endtask

  task automatic push_read(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    sb.push_back('{rv: 1'b1, data: d0, ack: 1'b0});
    sb.push_back('{rv: 1'b1, data: d1, ack: 1'b0});
    sb.push_back('{rv: 1'b1, data: d2, ack: 1'b0});
    sb.push_back('{rv: 1'b1, data: d3, ack: 1'b1});
  endtask

  initial begin
    int seen;
    int n;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",    {31'd0, bus.mem_busy},    32'd0);
    check("rst_rvalid",  {31'd0, bus.mem_rvalid},  32'd0);
    check("rst_ack",     {31'd0, bus.mem_ack},     32'd0);
    check("rst_overrun", {31'd0, bus.mem_overrun}, 32'd0);
    check("rst_rdata",   bus.mem_rdata,            32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, bus.mem_busy}, 32'd0);

    // Store timing: busy for 4 cycles, ack only in the 4th
    sb.push_back('{rv: 1'b0, data: 32'd0, ack: 1'b1});
    issue(1'b1, 10'h005, 32'hDEADBEEF);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("wr_busy_c%0d", k),   {31'd0, bus.mem_busy},   {31'd0, (k <= 4)});
      check($sformatf("wr_ack_c%0d", k),    {31'd0, bus.mem_ack},    {31'd0, (k == 4)});
      check($sformatf("wr_rvalid_c%0d", k), {31'd0, bus.mem_rvalid}, 32'd0);
      if (k < 5) @(negedge clk);
    end

    // Fill a block and read it back aligned, then wrapped
    store(10'h004, 32'h11);
    store(10'h005, 32'h22);
    store(10'h006, 32'h33);
    store(10'h007, 32'h44);
    push_read(32'h11, 32'h22, 32'h33, 32'h44);
    issue(1'b0, 10'h004, 32'h0);
    wait_idle();
    push_read(32'h33, 32'h44, 32'h11, 32'h22);
    issue(1'b0, 10'h006, 32'h0);
    wait_idle();

    // Request during a burst: flagged, ignored, burst unchanged
    push_read(32'h11, 32'h22, 32'h33, 32'h44);
    issue(1'b0, 10'h004, 32'h0);
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 10'h004;
    bus.mem_wdata = 32'h00000BAD;
    @(negedge clk);
    bus.mem_req   = 1'b0;
    check("overrun_set", {31'd0, bus.mem_overrun}, 32'd1);
    wait_idle();
    push_read(32'h22, 32'h33, 32'h44, 32'h11);
    issue(1'b0, 10'h005, 32'h0);
    wait_idle();
    check("overrun_sticky", {31'd0, bus.mem_overrun}, 32'd1);

    // Async reset after the second beat of a burst
    push_read(32'h11, 32'h22, 32'h33, 32'h44);
    issue(1'b0, 10'h004, 32'h0);
    seen = 0;
    n    = 0;
    while (n < 50) begin
      if (bus.mem_rvalid) seen++;
      if (seen == 2) break;
      @(negedge clk);
      n++;
    end
    check("beats_before_rst", seen, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    check("async_ack",    {31'd0, bus.mem_ack},    32'd0);
    check("async_busy",   {31'd0, bus.mem_busy},   32'd0);
    check("async_rdata",  bus.mem_rdata,           32'd0);
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rerst_busy",    {31'd0, bus.mem_busy},    32'd0);
    check("rerst_overrun", {31'd0, bus.mem_overrun}, 32'd0);
    push_read(32'h0, 32'h0, 32'h0, 32'h0);
    issue(1'b0, 10'h004, 32'h0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
